// File: rtl/led_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : led_shift_out
// Brief    : Serializes 96-bit backlight zone words MSB-first onto the LED
//            driver bus (sclk/sdi), then pulses a data or frame latch (lat).
// Revision : 1.0 - initial release
// ============================================================================
module led_shift_out #(
    parameter int DW    = 96,
    parameter int DIV   = 2,
    parameter int LAT_W = 1,
    parameter int VS_W  = 3
) (
    input  logic          clkb,
    input  logic          rst,
    input  logic [DW-1:0] datain,
    input  logic          latch_flag,
    input  logic          frame_flag,
    input  logic [6:0]    cntlatch,
    output logic          sclk,
    output logic          sdi,
    output logic          lat,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [6:0]    cur_idx
);

    localparam int PH_N  = 2 * DIV;
    localparam int PH_W  = (PH_N > 2) ? $clog2(PH_N) : 1;
    localparam int BIT_W = $clog2(DW);
    localparam int LC_N  = VS_W * 2 * DIV;
    localparam int LC_W  = $clog2(LC_N);

    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(PH_N - 1);
    localparam logic [PH_W-1:0]  c_ph_rise  = PH_W'(DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DW - 1);
    localparam logic [LC_W-1:0]  c_lat_data = LC_W'(LAT_W * 2 * DIV - 1);
    localparam logic [LC_W-1:0]  c_lat_vs   = LC_W'(VS_W * 2 * DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       r_state;
    logic [DW-1:0]    r_sreg;
    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bit;
    logic [LC_W-1:0]  r_lcnt;
    logic             r_vs;
    logic             r_sclk;
    logic             r_lat;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [6:0]       r_cur_idx;
    logic [LC_W-1:0]  w_lat_last;

    assign w_lat_last = r_vs ? c_lat_vs : c_lat_data;

    // sdi is the shift-register MSB; the final shift zero-fills it so the
    // line sits low through LATCH and IDLE without extra muxing.
    assign sdi     = r_sreg[DW-1];
    assign sclk    = r_sclk;
    assign lat     = r_lat;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign cur_idx = r_cur_idx;

    always_ff @(posedge clkb) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sreg    <= '0;
            r_phase   <= '0;
            r_bit     <= '0;
            r_lcnt    <= '0;
            r_vs      <= 1'b0;
            r_sclk    <= 1'b0;
            r_lat     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cur_idx <= '0;
        end else begin
            r_done <= 1'b0;
            if (latch_flag && (r_state != S_IDLE))
                r_ovf <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (latch_flag) begin
                        r_sreg    <= datain;
                        r_cur_idx <= cntlatch;
                        r_vs      <= frame_flag;
                        r_phase   <= '0;
                        r_bit     <= '0;
                        r_sclk    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_phase == c_ph_last) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        r_sreg  <= {r_sreg[DW-2:0], 1'b0};
                        if (r_bit == c_bit_last) begin
                            r_lat   <= 1'b1;
                            r_lcnt  <= '0;
                            r_state <= S_LATCH;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        if (r_phase == c_ph_rise)
                            r_sclk <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_lcnt == w_lat_last) begin
                        r_lat   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_shift_out
// Brief    : Directed self-checking bench for led_shift_out (DIV=2 and DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_shift_out;

    localparam logic [95:0] c_word = 96'hA5A5_0000_FFFF_1234_8001_7FFE;

    logic        clkb = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] datain = '0;
    logic        latch_flag = 1'b0;
    logic        frame_flag = 1'b0;
    logic [6:0]  cntlatch = '0;

    logic       s0_sclk, s0_sdi, s0_lat, s0_busy, s0_done, s0_ovf;
    logic [6:0] s0_idx;
    logic       s1_sclk, s1_sdi, s1_lat, s1_busy, s1_done, s1_ovf;
    logic [6:0] s1_idx;

    int sel = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic       m_sclk, m_sdi, m_lat, m_busy, m_done, m_ovf;
    logic [6:0] m_idx;

    assign m_sclk = (sel == 1) ? s1_sclk : s0_sclk;
    assign m_sdi  = (sel == 1) ? s1_sdi  : s0_sdi;
    assign m_lat  = (sel == 1) ? s1_lat  : s0_lat;
    assign m_busy = (sel == 1) ? s1_busy : s0_busy;
    assign m_done = (sel == 1) ? s1_done : s0_done;
    assign m_ovf  = (sel == 1) ? s1_ovf  : s0_ovf;
    assign m_idx  = (sel == 1) ? s1_idx  : s0_idx;

    always #5 clkb = ~clkb;

    led_shift_out #(.DW(96), .DIV(2), .LAT_W(1), .VS_W(3)) u_dut0 (
        .clkb(clkb), .rst(rst), .datain(datain), .latch_flag(latch_flag),
        .frame_flag(frame_flag), .cntlatch(cntlatch),
        .sclk(s0_sclk), .sdi(s0_sdi), .lat(s0_lat), .busy(s0_busy),
        .done(s0_done), .ovf(s0_ovf), .cur_idx(s0_idx)
    );

    led_shift_out #(.DW(96), .DIV(1), .LAT_W(1), .VS_W(3)) u_dut1 (
        .clkb(clkb), .rst(rst), .datain(datain), .latch_flag(latch_flag),
        .frame_flag(frame_flag), .cntlatch(cntlatch),
        .sclk(s1_sclk), .sdi(s1_sdi), .lat(s1_lat), .busy(s1_busy),
        .done(s1_done), .ovf(s1_ovf), .cur_idx(s1_idx)
    );

    // Called #1 after a rising edge; returns #1 into cycle t+1.
    task automatic strobe(input logic [95:0] d, input logic f, input logic [6:0] c);
        datain = d; frame_flag = f; cntlatch = c; latch_flag = 1'b1;
        @(posedge clkb); #1;
        latch_flag = 1'b0; frame_flag = 1'b0; cntlatch = '0; datain = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clkb); #1;
        rst = 1'b0;
    endtask

    // Measures one transfer starting in cycle t+1; stops in the done cycle
    // or at cycle max_n. Optionally injects a stray strobe in cycle ovf_at.
    task automatic observe(input int max_n, input int ovf_at,
                           output logic [95:0] cap, output int rises,
                           output int lat_start, output int lat_len,
                           output int done_at, output int busy_low,
                           output logic f_busy, output logic f_sdi, output logic f_sclk);
        logic prev;
        cap = '0; rises = 0; lat_start = -1; lat_len = 0; done_at = -1; busy_low = 0;
        prev = 1'b0;
        f_busy = m_busy; f_sdi = m_sdi; f_sclk = m_sclk;
        for (int n = 1; n <= max_n; n++) begin
            if (n == ovf_at) begin
                latch_flag = 1'b1; datain = '1; cntlatch = 7'd77; frame_flag = 1'b1;
            end else if (n == ovf_at + 1) begin
                latch_flag = 1'b0; datain = '0; cntlatch = '0; frame_flag = 1'b0;
            end
            if (m_sclk && !prev) begin
                rises++;
                cap = {cap[94:0], m_sdi};
            end
            prev = m_sclk;
            if (m_lat) begin
                if (lat_start < 0) lat_start = n;
                lat_len++;
            end
            if (m_done) begin
                done_at = n;
                break;
            end
            if (!m_busy) busy_low++;
            if (n == max_n) break;
            @(posedge clkb); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clkb);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({s0_sclk, s0_sdi, s0_lat, s0_busy, s0_done, s0_ovf, s0_idx} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {s0_sclk, s0_sdi, s0_lat, s0_busy, s0_done, s0_ovf, s0_idx});
        end
    endtask

    task automatic test_single();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        strobe(c_word, 1'b0, 7'd5);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if ({fb, fs, fc} !== 3'b110) begin n_bad++; $display("FAIL single_first_cycle: busy/sdi/sclk %b want 110", {fb, fs, fc}); end
        n_cmp++; if (cap !== c_word) begin n_bad++; $display("FAIL single_data: got %h want %h", cap, c_word); end
        n_cmp++; if (rises !== 96) begin n_bad++; $display("FAIL single_rises: got %0d want 96", rises); end
        n_cmp++; if (ls !== 385) begin n_bad++; $display("FAIL single_lat_start: got %0d want 385", ls); end
        n_cmp++; if (ll !== 4) begin n_bad++; $display("FAIL single_lat_len: got %0d want 4", ll); end
        n_cmp++; if (da !== 389) begin n_bad++; $display("FAIL single_done_at: got %0d want 389", da); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL single_busy_gap: got %0d want 0", bl); end
        n_cmp++; if (m_idx !== 7'd5) begin n_bad++; $display("FAIL single_cur_idx: got %0d want 5", m_idx); end
        n_cmp++; if ({m_busy, m_lat, m_ovf} !== 3'b000) begin n_bad++; $display("FAIL single_done_state: busy/lat/ovf %b want 000", {m_busy, m_lat, m_ovf}); end
        @(posedge clkb); #1;
        n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", m_done); end
    endtask

    task automatic test_frame();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        strobe(c_word, 1'b1, 7'd5);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (cap !== c_word) begin n_bad++; $display("FAIL frame_data: got %h want %h", cap, c_word); end
        n_cmp++; if (ls !== 385) begin n_bad++; $display("FAIL frame_lat_start: got %0d want 385", ls); end
        n_cmp++; if (ll !== 12) begin n_bad++; $display("FAIL frame_lat_len: got %0d want 12", ll); end
        n_cmp++; if (da !== 397) begin n_bad++; $display("FAIL frame_done_at: got %0d want 397", da); end
        n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL frame_ovf: got %b want 0", m_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        strobe(c_word, 1'b0, 7'd1);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (da !== 389) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 389", da); end
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done_busy: got %b want 0", m_busy); end
        strobe('1, 1'b0, 7'd2);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if ({fb, fs} !== 2'b11) begin n_bad++; $display("FAIL b2b_next_cycle: busy/sdi %b want 11", {fb, fs}); end
        n_cmp++; if (cap !== '1) begin n_bad++; $display("FAIL b2b_data: got %h want all ones", cap); end
        n_cmp++; if (da !== 389) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 389", da); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL b2b_busy_gap: got %0d want 0", bl); end
        n_cmp++; if (m_idx !== 7'd2) begin n_bad++; $display("FAIL b2b_cur_idx: got %0d want 2", m_idx); end
    endtask

    task automatic test_overflow();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        strobe(c_word, 1'b0, 7'd5);
        observe(1000, 100, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (cap !== c_word) begin n_bad++; $display("FAIL ovf_data: got %h want %h", cap, c_word); end
        n_cmp++; if (ll !== 4) begin n_bad++; $display("FAIL ovf_lat_len: got %0d want 4", ll); end
        n_cmp++; if (da !== 389) begin n_bad++; $display("FAIL ovf_done_at: got %0d want 389", da); end
        n_cmp++; if (m_idx !== 7'd5) begin n_bad++; $display("FAIL ovf_cur_idx: got %0d want 5", m_idx); end
        n_cmp++; if (m_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", m_ovf); end
        strobe(c_word, 1'b1, 7'd9);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (ll !== 12) begin n_bad++; $display("FAIL ovf_next_lat_len: got %0d want 12", ll); end
        n_cmp++; if (m_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_held: got %b want 1", m_ovf); end
        pulse_reset();
        n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b want 0", m_ovf); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        int lat_seen;
        strobe(c_word, 1'b1, 7'd3);
        observe(200, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        pulse_reset();
        n_cmp++;
        if ({m_sclk, m_sdi, m_lat, m_busy, m_done, m_ovf, m_idx} !== 13'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %b want 0", {m_sclk, m_sdi, m_lat, m_busy, m_done, m_ovf, m_idx});
        end
        lat_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_lat || m_busy || m_done) lat_seen++;
            @(posedge clkb); #1;
        end
        n_cmp++; if (lat_seen !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", lat_seen); end
        strobe(c_word, 1'b0, 7'd4);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (cap !== c_word) begin n_bad++; $display("FAIL rstmid_after_data: got %h want %h", cap, c_word); end
        n_cmp++; if (da !== 389) begin n_bad++; $display("FAIL rstmid_after_done: got %0d want 389", da); end
    endtask

    task automatic test_div1();
        logic [95:0] cap; int rises, ls, ll, da, bl; logic fb, fs, fc;
        sel = 1;
        pulse_reset();
        strobe(c_word, 1'b0, 7'd6);
        observe(1000, -1, cap, rises, ls, ll, da, bl, fb, fs, fc);
        n_cmp++; if (cap !== c_word) begin n_bad++; $display("FAIL div1_data: got %h want %h", cap, c_word); end
        n_cmp++; if (rises !== 96) begin n_bad++; $display("FAIL div1_rises: got %0d want 96", rises); end
        n_cmp++; if (ls !== 193) begin n_bad++; $display("FAIL div1_lat_start: got %0d want 193", ls); end
        n_cmp++; if (ll !== 2) begin n_bad++; $display("FAIL div1_lat_len: got %0d want 2", ll); end
        n_cmp++; if (da !== 195) begin n_bad++; $display("FAIL div1_done_at: got %0d want 195", da); end
        n_cmp++; if (m_idx !== 7'd6) begin n_bad++; $display("FAIL div1_cur_idx: got %0d want 6", m_idx); end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
